// File: rtl/fli_dff.sv
// Configurable flip-flop bank: load, hold, Johnson shift or toggle, with synchronous
// active-low reset and a combinational complement output.
module fli_dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QF
);

    localparam logic [1:0] MODE_LOAD   = 2'b00;
    localparam logic [1:0] MODE_HOLD   = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    logic [WIDTH-1:0] shift_next;

    // A one-bit twisted ring degenerates to an inverter.
    generate
        if (WIDTH == 1) begin : g_shift_1
            assign shift_next = ~Q;
        end else begin : g_shift_n
            assign shift_next = {Q[WIDTH-2:0], ~Q[WIDTH-1]};
        end
    endgenerate

    always_ff @(posedge CK) begin
        if (!RN) begin
            Q <= RESET_VAL;
        end else if (EN) begin
            case (MODE)
                MODE_LOAD:   Q <= D;
                MODE_HOLD:   Q <= Q;
                MODE_SHIFT:  Q <= shift_next;
                MODE_TOGGLE: Q <= ~Q;
                default:     Q <= Q;
            endcase
        end
    end

    assign QF = ~Q;

endmodule

// File: tb/tb_fli_dff.sv
// Directed bench for fli_dff: three instances share stimulus, expected values are queued
// when inputs are driven and compared one cycle later.
module tb_fli_dff;

    logic       clk = 1'b0;
    logic       rn, en;
    logic [1:0] mode;
    logic [3:0] d;

    logic       q1, qf1;
    logic [3:0] q4, qf4, q4r, qf4r;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] e1;
        logic [3:0] e4;
        logic [3:0] e4r;
    } sb_item_t;

    sb_item_t sb[$];
    logic [3:0] m1, m4, m4r;

    always #5 clk = ~clk;

    fli_dff #(.WIDTH(1)) u_w1 (
        .CK(clk), .RN(rn), .EN(en), .MODE(mode), .D(d[0]), .Q(q1), .QF(qf1));

    fli_dff #(.WIDTH(4)) u_w4 (
        .CK(clk), .RN(rn), .EN(en), .MODE(mode), .D(d), .Q(q4), .QF(qf4));

    fli_dff #(.WIDTH(4), .RESET_VAL(4'b0101)) u_w4r (
        .CK(clk), .RN(rn), .EN(en), .MODE(mode), .D(d), .Q(q4r), .QF(qf4r));

    function automatic logic [3:0] model(input int w, input logic [3:0] q, input logic r,
                                         input logic e, input logic [1:0] m,
                                         input logic [3:0] dd, input logic [3:0] rv);
        logic [3:0] mask;
        mask = (w == 1) ? 4'b0001 : 4'b1111;
        if (!r) return rv & mask;
        if (!e) return q;
        case (m)
            2'b00:   return dd & mask;
            2'b01:   return q;
            2'b10:   return (w == 1) ? (~q & mask) : {q[2:0], ~q[3]};
            default: return ~q & mask;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e1, input logic [3:0] e4,
                             input logic [3:0] e4r);
        check({tag, ".q1"},   {3'b000, q1},  e1);
        check({tag, ".qf1"},  {3'b000, qf1}, ~e1 & 4'b0001);
        check({tag, ".q4"},   q4,   e4);
        check({tag, ".qf4"},  qf4,  ~e4);
        check({tag, ".q4r"},  q4r,  e4r);
        check({tag, ".qf4r"}, qf4r, ~e4r);
    endtask

    // Drive one clock's inputs, queue the expected result, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] dd);
        sb_item_t it;
        @(negedge clk);
        rn = r; en = e; mode = m; d = dd;
        m1  = model(1, m1,  r, e, m, dd, 4'b0000);
        m4  = model(4, m4,  r, e, m, dd, 4'b0000);
        m4r = model(4, m4r, r, e, m, dd, 4'b0101);
        sb.push_back('{tag, m1, m4, m4r});
        @(posedge clk);
        #1;
        it = sb.pop_front();
        check_all(it.tag, it.e1, it.e4, it.e4r);
    endtask

    logic [3:0] johnson_seq [8];

    initial begin
        johnson_seq = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                        4'b1100, 4'b1000, 4'b0000, 4'b0001};
        rn = 1'b1; en = 1'b0; mode = 2'b01; d = 4'b0000;
        m1 = 'x; m4 = 'x; m4r = 'x;

        // Reset wins over an enabled load of all ones.
        step("rst_prio", 1'b0, 1'b1, 2'b00, 4'b1111);
        check("rst_q4r_const", q4r, 4'b0101);
        step("toggle", 1'b1, 1'b1, 2'b11, 4'b1111);
        check("toggle_q4r_const", q4r, 4'b1010);

        // Single-bit load 1 then 0.
        step("rst2", 1'b0, 1'b0, 2'b01, 4'b0000);
        step("w1_load1", 1'b1, 1'b1, 2'b00, 4'b0001);
        check("w1_load1_const", {3'b000, q1}, 4'b0001);
        step("w1_load0", 1'b1, 1'b1, 2'b00, 4'b0000);
        check("w1_load0_const", {3'b000, qf1}, 4'b0001);

        // Johnson ring from 0001 visits the full 2*WIDTH cycle.
        step("load0001", 1'b1, 1'b1, 2'b00, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("shift%0d", i), 1'b1, 1'b1, 2'b10, $urandom_range(0, 15));
            check($sformatf("johnson%0d", i), q4, johnson_seq[i]);
        end

        // Reset in the middle of a ring sequence restarts from RESET_VAL.
        step("shift_a", 1'b1, 1'b1, 2'b10, 4'b0000);
        step("shift_b", 1'b1, 1'b1, 2'b10, 4'b0000);
        step("rst_mid", 1'b0, 1'b1, 2'b10, 4'b0000);
        step("shift_after_rst", 1'b1, 1'b1, 2'b10, 4'b0000);
        check("shift_after_rst_const", q4r, 4'b1011);

        // Enable low holds through every mode and random data.
        step("load1010", 1'b1, 1'b1, 2'b00, 4'b1010);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("en0_%0d", i), 1'b1, 1'b0, 2'(i), $urandom_range(0, 15));
            check($sformatf("en0_q_%0d", i), q4, 4'b1010);
            check($sformatf("en0_qf_%0d", i), qf4, 4'b0101);
        end

        // Glitches on D/EN/MODE/RN inside the high and low phases must be ignored.
        step("pre_glitch", 1'b1, 1'b1, 2'b01, 4'b0000);
        rn = 1'b0; en = 1'b1; mode = 2'b00; d = 4'b1111;
        #2;
        rn = 1'b1; en = 1'b1; mode = 2'b01; d = 4'b0000;
        #1;
        check_all("glitch_hi", m1, m4, m4r);
        @(negedge clk);
        #1;
        rn = 1'b0; mode = 2'b11; d = 4'b0101;
        #2;
        rn = 1'b1; mode = 2'b01; d = 4'b0000;
        @(posedge clk);
        #1;
        check_all("glitch_lo", m1, m4, m4r);
        step("post_glitch", 1'b1, 1'b1, 2'b01, 4'b0000);

        check("sb_empty", 4'(sb.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fli_dff.md
FLI_DFF -- requirements
Module: fli_dff

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of flip-flop bits, legal range 1..32.
REQ-002 SHALL have parameter RESET_VAL, default 0: WIDTH-bit value loaded into Q on reset.
REQ-003 SHALL have port CK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port RN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port EN, input, 1 bit: clock enable; 1 = update state per MODE, 0 = hold.
REQ-006 SHALL have port MODE, input, 2 bits: 00 = load D, 01 = hold, 10 = Johnson shift, 11 = toggle.
REQ-007 SHALL have port D, input, WIDTH bits: data input captured in load mode.
REQ-008 SHALL have port Q, output, WIDTH bits: registered state.
REQ-009 SHALL have port QF, output, WIDTH bits: bitwise complement of Q.

Function
REQ-010 SHALL keep all state in one WIDTH-bit register Q, updated only on the CK rising edge.
REQ-011 SHALL drive QF combinationally as ~Q at all times, with no extra register and no cycle offset.
REQ-012 When RN=1, EN=1 and MODE=00, Q SHALL take the value D sampled at the rising edge (latency 1 cycle).
REQ-013 When RN=1, EN=1 and MODE=01, Q SHALL hold its value.
REQ-014 When RN=1, EN=1 and MODE=10, Q SHALL become {Q[WIDTH-2:0], ~Q[WIDTH-1]} (twisted-ring shift, bit 0 receives ~MSB).
REQ-015 For WIDTH=1 in MODE=10, Q SHALL become ~Q.
REQ-016 When RN=1, EN=1 and MODE=11, Q SHALL become ~Q (all bits toggle).
REQ-017 When RN=1 and EN=0, Q SHALL hold regardless of MODE and D.
REQ-018 Changes on D, EN or MODE between rising edges, including changes while CK is low or high, SHALL have no effect on Q.
REQ-019 Starting from all zeros, repeated MODE=10 cycles SHALL visit 2*WIDTH distinct states and then return to all zeros.
REQ-020 Q SHALL be X-free after the first reset edge, independent of D.

Reset
REQ-021 RN=0 at a CK rising edge SHALL set Q=RESET_VAL and QF=~RESET_VAL on that edge.
REQ-022 Reset SHALL take priority over EN, MODE and D.
REQ-023 RN SHALL be sampled only at the CK rising edge; an RN pulse that does not span a rising edge SHALL have no effect.
REQ-024 Reset asserted during a Johnson sequence SHALL abort the sequence, and the first enabled shift after RN returns to 1 SHALL start from RESET_VAL.

Verification
REQ-025 WIDTH=1: RN=0 for one edge, then RN=1, EN=1, MODE=00, D=1 -> Q=1 and QF=0 after the next rising edge; D=0 -> Q=0 and QF=1 after the following edge.
REQ-026 WIDTH=4: reset, then MODE=00 loading D=0000 then D=0001 -> Q=0001; then MODE=10 for 8 edges -> Q sequence 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
REQ-027 WIDTH=4: Q=1010, EN=0 with MODE toggling through all codes and D randomized for 5 edges -> Q stays 1010 and QF stays 0101.
REQ-028 WIDTH=4, RESET_VAL=0101: RN=0 together with EN=1, MODE=00, D=1111 -> Q=0101 after the edge; MODE=11 on the next edge -> Q=1010.
REQ-029 D pulse asserted and removed entirely between two rising edges -> Q unchanged; QF equals ~Q at every sample point throughout all tests.
